// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the PC sequencer and its optional return stack.
// The return stack is built only when SEQ_RET_STACK_EN is defined.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    EXEC,
    HALT
  } seq_state_t;

  localparam int AW_DEFAULT       = 8;
  localparam int RS_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/seq_ret_stack.sv
// Hardware return-address LIFO; a push onto a full stack overwrites the oldest
// entry (circular), and the over/underflow flags pulse for one cycle after the event.
module seq_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int AW    = AW_DEFAULT,
  parameter int DEPTH = RS_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_inc;
  logic [PW-1:0] sp_dec;
  logic [CW-1:0] count;

  // sp is the next free slot; once full it also points at the oldest entry
  always_comb begin
    sp_inc = (sp == PW'(DEPTH - 1)) ? '0 : sp + PW'(1);
    sp_dec = (sp == '0) ? PW'(DEPTH - 1) : sp - PW'(1);
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign top   = empty ? '0 : mem[sp_dec];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      overflow  <= push && full;
      underflow <= !push && pop && empty;
      if (push) begin
        mem[sp] <= push_data;
        sp      <= sp_inc;
        if (!full) begin
          count <= count + CW'(1);
        end
      end else if (pop && !empty) begin
        sp    <= sp_dec;
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Control FSM sequencing the program counter: fetch handshakes, increment, branches.
// Define SEQ_RET_STACK_EN to add hardware call/return through seq_ret_stack.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int AW = AW_DEFAULT
`ifdef SEQ_RET_STACK_EN
  ,
  parameter int RS_DEPTH = RS_DEPTH_DEFAULT
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [AW-1:0] pc_cur,
  output logic          pc_en,
  output logic [AW-1:0] pc_next,
  output logic          fetch_req,
  input  logic          fetch_ack,
  input  logic          instr_len2,
  input  logic          exec_stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          halt_instr,
`ifdef SEQ_RET_STACK_EN
  input  logic          call_instr,
  input  logic          ret_instr,
  output logic          rs_overflow,
  output logic          rs_underflow,
`endif
  output logic          busy,
  output logic          halted
);

  seq_state_t state;

`ifdef SEQ_RET_STACK_EN
  logic          rs_push;
  logic          rs_pop;
  logic [AW-1:0] rs_top;
  logic          rs_full;
  logic          rs_empty;

  seq_ret_stack #(
    .AW    (AW),
    .DEPTH (RS_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (rs_push),
    .pop       (rs_pop),
    .push_data (pc_cur),
    .top       (rs_top),
    .full      (rs_full),
    .empty     (rs_empty),
    .overflow  (rs_overflow),
    .underflow (rs_underflow)
  );
`endif

  assign fetch_req = (state == FETCH1) || (state == FETCH2);
  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);

  // PC load is combinational so the PC register updates on the transition edge
  always_comb begin
    pc_en   = 1'b0;
    pc_next = '0;
`ifdef SEQ_RET_STACK_EN
    rs_push = 1'b0;
    rs_pop  = 1'b0;
`endif
    if (!reset) begin
      case (state)
        FETCH1, FETCH2: begin
          if (fetch_ack) begin
            pc_en   = 1'b1;
            pc_next = pc_cur + AW'(1);
          end
        end
        EXEC: begin
          if (!exec_stall && !halt_instr) begin
`ifdef SEQ_RET_STACK_EN
            if (ret_instr) begin
              rs_pop  = 1'b1;
              pc_en   = 1'b1;
              pc_next = rs_top;
            end else if (call_instr) begin
              rs_push = 1'b1;
              pc_en   = 1'b1;
              pc_next = br_target;
            end else if (br_taken) begin
              pc_en   = 1'b1;
              pc_next = br_target;
            end
`else
            if (br_taken) begin
              pc_en   = 1'b1;
              pc_next = br_target;
            end
`endif
          end
        end
        default: begin
          pc_en   = 1'b0;
          pc_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH1;
          end
        end
        FETCH1: begin
          if (fetch_ack) begin
            state <= instr_len2 ? FETCH2 : EXEC;
          end
        end
        FETCH2: begin
          if (fetch_ack) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!exec_stall) begin
            state <= halt_instr ? HALT : FETCH1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; the return-stack scenarios
// are included when SEQ_RET_STACK_EN is defined.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          run;
  logic [AW-1:0] pc_cur;
  logic          pc_en;
  logic [AW-1:0] pc_next;
  logic          fetch_req;
  logic          fetch_ack;
  logic          instr_len2;
  logic          exec_stall;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic          halt_instr;
  logic          busy;
  logic          halted;
`ifdef SEQ_RET_STACK_EN
  logic          call_instr;
  logic          ret_instr;
  logic          rs_overflow;
  logic          rs_underflow;
`endif

  int errorCount = 0;
  int checkCount = 0;

  pc_sequencer #(.AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .pc_cur       (pc_cur),
    .pc_en        (pc_en),
    .pc_next      (pc_next),
    .fetch_req    (fetch_req),
    .fetch_ack    (fetch_ack),
    .instr_len2   (instr_len2),
    .exec_stall   (exec_stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .halt_instr   (halt_instr),
`ifdef SEQ_RET_STACK_EN
    .call_instr   (call_instr),
    .ret_instr    (ret_instr),
    .rs_overflow  (rs_overflow),
    .rs_underflow (rs_underflow),
`endif
    .busy         (busy),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the per-cycle inputs, then let the combinational outputs settle
  task automatic applyStimulus(input logic r, input logic ack, input logic len2,
                               input logic stall, input logic br, input logic hlt,
                               input logic [AW-1:0] pc, input logic [AW-1:0] tgt);
    run        = r;
    fetch_ack  = ack;
    instr_len2 = len2;
    exec_stall = stall;
    br_taken   = br;
    halt_instr = hlt;
    pc_cur     = pc;
    br_target  = tgt;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef SEQ_RET_STACK_EN
  int ovfPulses = 0;
  int unfPulses = 0;

  // From FETCH1: one 1-byte fetch, then an EXEC cycle carrying call or ret
  task automatic doStackOp(input logic is_call, input logic is_ret, input logic [AW-1:0] exec_pc,
                           input logic [AW-1:0] tgt, output logic en, output logic [AW-1:0] nxt);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exec_pc - 8'd1, 8'h00);
    step();
    call_instr = is_call;
    ret_instr  = is_ret;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exec_pc, tgt);
    en  = pc_en;
    nxt = pc_next;
    if (rs_overflow) ovfPulses++;
    if (rs_underflow) unfPulses++;
    step();
    call_instr = 1'b0;
    ret_instr  = 1'b0;
    #1;
    if (rs_overflow) ovfPulses++;
    if (rs_underflow) unfPulses++;
  endtask
`endif

  initial begin
`ifdef SEQ_RET_STACK_EN
    logic          en;
    logic [AW-1:0] nxt;
    call_instr = 1'b0;
    ret_instr  = 1'b0;
`endif
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    step();
    checkOutput("rst_pc_en", pc_en, 1'b0);
    checkOutput("rst_pc_next", pc_next, 8'h00);
    checkOutput("rst_fetch_req", fetch_req, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);

    // 1-byte instruction with same-cycle ack at 0x10
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    checkOutput("idle_busy", busy, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    checkOutput("f1_req", fetch_req, 1'b1);
    checkOutput("f1_busy", busy, 1'b1);
    checkOutput("f1_pc_en", pc_en, 1'b1);
    checkOutput("f1_pc_next", pc_next, 8'h11);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h00);
    checkOutput("ex_req", fetch_req, 1'b0);
    checkOutput("ex_busy", busy, 1'b1);
    checkOutput("ex_pc_en", pc_en, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
    checkOutput("back_f1_req", fetch_req, 1'b1);
    checkOutput("back_f1_busy", busy, 1'b1);

    // 2-byte instruction at 0x20
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00);
    checkOutput("l2_f1_pc_next", pc_next, 8'h21);
    checkOutput("l2_f1_pc_en", pc_en, 1'b1);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h21, 8'h00);
    checkOutput("l2_f2_req", fetch_req, 1'b1);
    checkOutput("l2_f2_pc_en", pc_en, 1'b1);
    checkOutput("l2_f2_pc_next", pc_next, 8'h22);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00);
    checkOutput("l2_ex_req", fetch_req, 1'b0);
    checkOutput("l2_ex_ack_ignored", pc_en, 1'b0);
    step();

    // Stalled branch: stall outranks halt and branch
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h30, 8'h00);
    checkOutput("br_f1_pc_next", pc_next, 8'h31);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h31, 8'h05);
      checkOutput("stall_pc_en", pc_en, 1'b0);
      checkOutput("stall_busy", busy, 1'b1);
      checkOutput("stall_req", fetch_req, 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h31, 8'h05);
    checkOutput("br_pc_en", pc_en, 1'b1);
    checkOutput("br_pc_next", pc_next, 8'h05);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
    checkOutput("br_to_f1_req", fetch_req, 1'b1);

    // Wrap at 0xFF with the ack delayed two cycles
    for (int i = 0; i < 2; i++) begin
      checkOutput("wait_req", fetch_req, 1'b1);
      checkOutput("wait_pc_en", pc_en, 1'b0);
      step();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00);
    checkOutput("wrap_req", fetch_req, 1'b1);
    checkOutput("wrap_pc_en", pc_en, 1'b1);
    checkOutput("wrap_pc_next", pc_next, 8'h00);
    step();

    // Halt: only reset leaves HALT
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h44);
    checkOutput("halt_ex_pc_en", pc_en, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(i[0], 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      checkOutput("halt_halted", halted, 1'b1);
      checkOutput("halt_busy", busy, 1'b0);
      checkOutput("halt_pc_en", pc_en, 1'b0);
      checkOutput("halt_req", fetch_req, 1'b0);
      step();
    end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("unhalt_halted", halted, 1'b0);
    checkOutput("unhalt_busy", busy, 1'b0);

    // Reset in FETCH2 aborts the pending fetch
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00);
    step();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00);
    checkOutput("f2rst_f1_pc_next", pc_next, 8'h41);
    step();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 8'h00);
    checkOutput("f2rst_pc_en", pc_en, 1'b0);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41, 8'h00);
    checkOutput("f2rst_req", fetch_req, 1'b0);
    checkOutput("f2rst_busy", busy, 1'b0);

`ifdef SEQ_RET_STACK_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    doStackOp(1'b1, 1'b0, 8'h30, 8'h40, en, nxt);
    checkOutput("call_pc_en", en, 1'b1);
    checkOutput("call_pc_next", nxt, 8'h40);
    doStackOp(1'b0, 1'b1, 8'h41, 8'h00, en, nxt);
    checkOutput("ret_pc_en", en, 1'b1);
    checkOutput("ret_pc_next", nxt, 8'h30);
    for (int i = 0; i < 5; i++) begin
      doStackOp(1'b1, 1'b0, 8'h50 + 8'(i), 8'h60, en, nxt);
    end
    checkOutput("ovf_pulses", ovfPulses, 1);
    for (int i = 0; i < 4; i++) begin
      doStackOp(1'b0, 1'b1, 8'h61, 8'h00, en, nxt);
      checkOutput("ovf_ret_pc_next", nxt, 8'h54 - 8'(i));
    end
    checkOutput("no_unf_yet", unfPulses, 0);
    doStackOp(1'b0, 1'b1, 8'h61, 8'h00, en, nxt);
    checkOutput("unf_pc_next", nxt, 8'h00);
    checkOutput("unf_pc_en", en, 1'b1);
    checkOutput("unf_pulses", unfPulses, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
